// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, line-rate defaults and tick divider helper
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CLK_HZ_DEF     = 100_000_000;
    localparam int BAUD_DEF       = 115_200;
    localparam int OVERSAMPLE_DEF = 16;

    function automatic int div_calc(input int clk_hz, input int baud_rate, input int oversample);
        return clk_hz / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/baud_unit.sv
// baud_unit: free-running divider emitting a one-clock oversample tick every DIV clocks
module baud_unit import uart_pkg::*; #(
    parameter int DIV = div_calc(CLK_HZ_DEF, BAUD_DEF, OVERSAMPLE_DEF)
) (
    input  logic clk,
    input  logic reset,
    output logic baud
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign baud = cnt == CW'(DIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= baud ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8N1 deserializer with mid-bit sampling and hold-able output byte
module uart_receiver import uart_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int BAUD_RATE  = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV        = div_calc(CLK_HZ, BAUD_RATE, OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             hold_value,
    output logic [WIDTH-1:0] rx,
    output logic             start,
    output logic             rx_valid,
    output logic             frame_err
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic             baud;
    logic [1:0]       sync;
    logic             data_s;
    state_t           state, state_n;
    logic [3:0]       tcnt, tcnt_n;
    logic [BW-1:0]    bidx, bidx_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic             load, ferr;

    baud_unit #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .reset(reset),
        .baud (baud)
    );

    assign data_s = sync[1];
    assign start  = state != IDLE;

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bidx_n  = bidx;
        sh_n    = sh;
        load    = 1'b0;
        ferr    = 1'b0;
        if (baud) begin
            case (state)
                IDLE: if (!data_s) begin
                    state_n = START;
                    tcnt_n  = '0;
                end
                START: if (tcnt == MID) begin
                    state_n = data_s ? IDLE : DATA;
                    tcnt_n  = '0;
                    bidx_n  = '0;
                end else
                    tcnt_n = tcnt + 4'd1;
                DATA: begin
                    tcnt_n = (tcnt == LAST) ? '0 : tcnt + 4'd1;
                    if (tcnt == LAST) begin
                        sh_n   = {data_s, sh[WIDTH-1:1]};
                        bidx_n = bidx + 1'b1;
                        state_n = (bidx == BW'(WIDTH - 1)) ? STOP : DATA;
                    end
                end
                STOP: begin
                    tcnt_n = (tcnt == LAST) ? '0 : tcnt + 4'd1;
                    if (tcnt == LAST) begin
                        state_n = IDLE;
                        load    = data_s && !hold_value;
                        ferr    = !data_s;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= 2'b11;
            state     <= IDLE;
            tcnt      <= '0;
            bidx      <= '0;
            sh        <= '0;
            rx        <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], data};
            state     <= state_n;
            tcnt      <= tcnt_n;
            bidx      <= bidx_n;
            sh        <= sh_n;
            rx        <= load ? sh : rx;
            rx_valid  <= load;
            frame_err <= ferr;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random 8N1 frames checked against a frame-level model
module tb_uart_receiver;
    localparam int BIT = 8675;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data = 1'b1;
    logic       hold_value = 1'b0;
    logic [7:0] rx;
    logic       start, rx_valid, frame_err;

    int n_chk = 0, n_fail = 0;
    int n_valid = 0, n_ferr = 0, start_cyc = 0;
    logic [7:0] exp_rx = 8'h00;

    uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .hold_value(hold_value),
        .rx        (rx),
        .start     (start),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_ferr++;
        if (start) start_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        data = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            data = b[i];
            #BIT;
        end
        data = stop;
        #BIT;
        data = 1'b1;
        if (!stop) #(BIT / 2);
        @(negedge clk);
    endtask

    // Model: a frame loads rx only with a high stop bit and no hold; a low stop bit flags an error.
    task automatic frame(input logic [7:0] b, input logic stop, input logic hold, input string tag);
        int v0, f0, s0, ds;
        v0 = n_valid;
        f0 = n_ferr;
        s0 = start_cyc;
        hold_value = hold;
        send(b, stop);
        hold_value = 1'b0;
        if (stop && !hold) exp_rx = b;
        ds = start_cyc - s0;
        chk({tag, " rx"}, rx, exp_rx);
        chk({tag, " rx_valid pulses"}, n_valid - v0, (stop && !hold) ? 1 : 0);
        chk({tag, " frame_err pulses"}, n_ferr - f0, stop ? 0 : 1);
        chk({tag, " start idle after"}, start, 1'b0);
        if (stop) chk({tag, " start span"}, (ds >= 8150 && ds <= 8300), 1'b1);
    endtask

    initial begin
        int nb, first, per, s0, v0, ds;
        logic [7:0] rb;
        logic rh, rs;
        nb = 0;
        repeat (100) begin
            @(negedge clk);
            if (dut.baud) nb++;
        end
        chk("reset baud silent", nb, 0);
        chk("reset rx", rx, 8'h00);
        chk("reset start", start, 1'b0);
        chk("reset rx_valid", rx_valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        reset = 1'b0;
        first = -1;
        per = 0;
        for (int i = 0; i < 200 && per == 0; i++) begin
            @(negedge clk);
            if (dut.baud) begin
                if (first < 0) first = i;
                else per = i - first;
            end
        end
        chk("baud period", per, 54);
        #BIT;
        @(negedge clk);

        frame(8'h99, 1'b1, 1'b0, "frame 99");
        frame(8'h5A, 1'b1, 1'b1, "hold 5A");
        frame(8'hA5, 1'b1, 1'b0, "frame A5");

        s0 = start_cyc;
        v0 = n_valid;
        data = 1'b0;
        #2000;
        data = 1'b1;
        #BIT;
        @(negedge clk);
        ds = start_cyc - s0;
        chk("glitch start within START", (ds > 0 && ds <= 9 * 54), 1'b1);
        chk("glitch rx_valid", n_valid - v0, 0);
        chk("glitch rx", rx, exp_rx);
        chk("glitch start idle", start, 1'b0);

        frame(8'h3C, 1'b0, 1'b0, "ferr 3C");
        frame(8'hC3, 1'b1, 1'b0, "frame C3");

        rb = 8'h6E;
        data = 1'b0;
        #BIT;
        for (int i = 0; i < 4; i++) begin
            data = rb[i];
            #BIT;
        end
        data = rb[4];
        #(BIT / 2);
        chk("mid-frame start before reset", start, 1'b1);
        reset = 1'b1;
        #1;
        exp_rx = 8'h00;
        chk("mid-frame reset rx", rx, exp_rx);
        chk("mid-frame reset start", start, 1'b0);
        data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #BIT;
        @(negedge clk);
        chk("after reset start idle", start, 1'b0);
        frame(8'h81, 1'b1, 1'b0, "post-reset 81");

        for (int k = 0; k < 2; k++) begin
            rb = 8'($urandom);
            rh = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 4) != 0);
            frame(rb, rs, rh, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
